branch_metric: RTL and testbench

- Gamma stage of the max-log-MAP SISO decoder. Sits directly upstream of the forward (alpha) recursion.
- Accepts one block of systematic, parity and a-priori LLR triples and computes the two branch metrics per trellis step.
- Streams the metrics forward to the alpha stage, paced one step per two cycles.
- Buffers them and replays them in reverse order for the backward (beta) stage.
- Drives fsm_state, which also clears the alpha stage in IDLE.

---
 rtl/branch_metric.sv | 158 +++++++++++++++
 tb/tb_branch_metric.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_metric.sv
// Gamma stage of the max-log-MAP SISO: streams b1/b2 to alpha and replays them reversed for beta.
// Optional: define BM_SAT_EN to saturate b1/b2; otherwise they wrap to IN_W bits.
module branch_metric #(
    parameter int IN_W   = 16,
    parameter int MAX_K  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   blk_len,
    input  logic [IN_W-1:0]   sys_llr,
    input  logic [IN_W-1:0]   par_llr,
    input  logic [IN_W-1:0]   apr_llr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IN_W-1:0]   init_branch1,
    output logic [IN_W-1:0]   init_branch2,
    output logic              valid_branch,
    output logic [IN_W-1:0]   rev_branch1,
    output logic [IN_W-1:0]   rev_branch2,
    output logic              rev_valid,
    output logic [1:0]        fsm_state,
    output logic              done
);

    localparam int EXT_W = IN_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FWD  = 2'b01,
        S_BWD  = 2'b10,
        S_DONE = 2'b11
    } state_t;

`ifdef BM_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(IN_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(IN_W-1){1'b0}}};

    function automatic logic [IN_W-1:0] fit(input logic signed [EXT_W-1:0] v);
        if (v > SAT_MAX)      fit = IN_W'(SAT_MAX);
        else if (v < SAT_MIN) fit = IN_W'(SAT_MIN);
        else                  fit = IN_W'(v);
    endfunction
`else
    function automatic logic [IN_W-1:0] fit(input logic signed [EXT_W-1:0] v);
        fit = IN_W'(v);
    endfunction
`endif

    state_t                   r_state, w_state_nxt;
    logic [ADDR_W:0]          r_k, r_cnt, w_klen;
    logic                     r_gap, r_valid, r_ph, r_last, r_rev_valid, r_done;
    logic [IN_W-1:0]          r_b1, r_b2, r_rev1, r_rev2;
    logic [ADDR_W-1:0]        r_raddr;
    logic [2*IN_W-1:0]        r_rdata;
    logic [2*IN_W-1:0]        r_mem [0:(1<<ADDR_W)-1];

    logic signed [EXT_W-1:0]  w_sys, w_apr, w_par, w_sum, w_dif, w_h1, w_h2;
    logic [IN_W-1:0]          w_b1, w_b2;
    logic                     w_ready, w_accept, w_rd_en, w_rev_load;

    always_comb begin
        w_sys = {{2{sys_llr[IN_W-1]}}, sys_llr};
        w_apr = {{2{apr_llr[IN_W-1]}}, apr_llr};
        w_par = {{2{par_llr[IN_W-1]}}, par_llr};
        w_sum = w_sys + w_apr + w_par;
        w_dif = w_sys + w_apr - w_par;
        w_h1  = w_sum >>> 1;
        w_h2  = w_dif >>> 1;
        w_b1  = fit(w_h1);
        w_b2  = fit(w_h2);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_klen      = (blk_len > (ADDR_W+1)'(MAX_K)) ? (ADDR_W+1)'(MAX_K) : blk_len;
        w_ready     = (r_state == S_FWD) && !r_gap && (r_cnt != r_k);
        w_accept    = in_valid && w_ready;
        // Even phase issues the RAM read, odd phase registers the returned pair.
        w_rd_en     = (r_state == S_BWD) && !r_ph && !r_last;
        w_rev_load  = (r_state == S_BWD) && r_ph;
        case (r_state)
            S_IDLE:  if (start && (blk_len != '0)) w_state_nxt = S_FWD;
            S_FWD:   if (r_valid && (r_cnt == r_k)) w_state_nxt = S_BWD;
            S_BWD:   if (r_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k         <= '0;
            r_cnt       <= '0;
            r_gap       <= 1'b0;
            r_valid     <= 1'b0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_raddr     <= '0;
            r_ph        <= 1'b0;
            r_last      <= 1'b0;
            r_rev1      <= '0;
            r_rev2      <= '0;
            r_rev_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_valid     <= w_accept;
            r_gap       <= w_accept;
            r_rev_valid <= w_rev_load;
            r_done      <= (r_state == S_BWD) && r_last;
            if ((r_state == S_IDLE) && (w_state_nxt == S_FWD)) begin
                r_k    <= w_klen;
                r_cnt  <= '0;
                r_last <= 1'b0;
            end
            if (w_accept) begin
                r_b1  <= w_b1;
                r_b2  <= w_b2;
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_FWD) && (w_state_nxt == S_BWD)) begin
                r_raddr <= ADDR_W'(r_k - 1'b1);
                r_ph    <= 1'b0;
            end
            if (w_rd_en) r_ph <= 1'b1;
            if (w_rev_load) begin
                r_rev1  <= r_rdata[2*IN_W-1:IN_W];
                r_rev2  <= r_rdata[IN_W-1:0];
                r_ph    <= 1'b0;
                r_raddr <= r_raddr - 1'b1;
                if (r_raddr == '0) r_last <= 1'b1;
            end
            if (r_state == S_DONE) r_last <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_cnt[ADDR_W-1:0]] <= {w_b1, w_b2};
        if (w_rd_en)  r_rdata <= r_mem[r_raddr];
    end

    assign in_ready     = w_ready;
    assign init_branch1 = r_b1;
    assign init_branch2 = r_b2;
    assign valid_branch = r_valid;
    assign rev_branch1  = r_rev1;
    assign rev_branch2  = r_rev2;
    assign rev_valid    = r_rev_valid;
    assign fsm_state    = r_state;
    assign done         = r_done;

endmodule

// File: tb/tb_branch_metric.sv
// Scoreboard bench for branch_metric: driver queues expected pairs, negedge monitor checks them.
module tb_branch_metric;
    localparam int IN_W = 16;
    localparam int ADDR_W = 9;

    logic              clk, rst_n, start, in_valid, in_ready;
    logic [ADDR_W:0]   blk_len;
    logic [IN_W-1:0]   sys_llr, par_llr, apr_llr;
    logic [IN_W-1:0]   init_branch1, init_branch2, rev_branch1, rev_branch2;
    logic              valid_branch, rev_valid, done;
    logic [1:0]        fsm_state;

    branch_metric #(.IN_W(IN_W), .MAX_K(512), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .blk_len(blk_len),
        .sys_llr(sys_llr), .par_llr(par_llr), .apr_llr(apr_llr),
        .in_valid(in_valid), .in_ready(in_ready),
        .init_branch1(init_branch1), .init_branch2(init_branch2), .valid_branch(valid_branch),
        .rev_branch1(rev_branch1), .rev_branch2(rev_branch2), .rev_valid(rev_valid),
        .fsm_state(fsm_state), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int b1; int b2; } pair_t;
    pair_t fq[$];
    pair_t rq[$];
    int q_sys[$], q_apr[$], q_par[$], q_e1[$], q_e2[$];
    int slog[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0, fwd_cnt = 0, rev_cnt = 0, done_cnt = 0, bad_cnt = 0, spacing_err = 0;
    int last_fwd_cyc = 0, last_rev_cyc = 0, t_bwd = 0, t_first_rev = 0;
    logic first_rev_pending = 1'b0;
    logic [1:0] last_state = 2'b00;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int floor_half(input int x);
        return (x >= 0) ? x / 2 : -((1 - x) / 2);
    endfunction

    function automatic int fit(input int x);
`ifdef BM_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
`else
        int w;
        w = x & 32'h0000FFFF;
        return (w >= 32768) ? w - 65536 : w;
`endif
    endfunction

    task automatic add(input int s, input int a, input int p, input int e1, input int e2);
        q_sys.push_back(s); q_apr.push_back(a); q_par.push_back(p);
        q_e1.push_back(e1); q_e2.push_back(e2);
    endtask

    task automatic add_model(input int s, input int a, input int p);
        add(s, a, p, fit(floor_half(s + a + p)), fit(floor_half(s + a - p)));
    endtask

    task automatic clear_vec();
        q_sys.delete(); q_apr.delete(); q_par.delete(); q_e1.delete(); q_e2.delete();
    endtask

    always @(negedge clk) begin
        pair_t p;
        cyc++;
        if (!rst_n) begin
            last_state = 2'b00;
            first_rev_pending = 1'b0;
        end else begin
            if (fsm_state != last_state) begin
                slog.push_back(int'(fsm_state));
                if (fsm_state == 2'b10) begin
                    t_bwd = cyc;
                    first_rev_pending = 1'b1;
                end
                last_state = fsm_state;
            end
            if (valid_branch) begin
                if (cyc - last_fwd_cyc < 2) spacing_err++;
                last_fwd_cyc = cyc;
                fwd_cnt++;
                if (fq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL fwd_extra: strobe b1=%0d b2=%0d, expected no strobe",
                             int'($signed(init_branch1)), int'($signed(init_branch2)));
                end else begin
                    p = fq.pop_front();
                    chk("fwd_b1", int'($signed(init_branch1)), p.b1);
                    chk("fwd_b2", int'($signed(init_branch2)), p.b2);
                end
            end
            if (rev_valid) begin
                if (cyc - last_rev_cyc < 2) spacing_err++;
                if (first_rev_pending) t_first_rev = cyc;
                first_rev_pending = 1'b0;
                last_rev_cyc = cyc;
                rev_cnt++;
                if (rq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL rev_extra: strobe b1=%0d b2=%0d, expected no strobe",
                             int'($signed(rev_branch1)), int'($signed(rev_branch2)));
                end else begin
                    p = rq.pop_front();
                    chk("rev_b1", int'($signed(rev_branch1)), p.b1);
                    chk("rev_b2", int'($signed(rev_branch2)), p.b2);
                end
            end
            if (done) begin
                done_cnt++;
                if (fsm_state != 2'b11) bad_cnt++;
            end
            if (in_ready && fsm_state != 2'b01) bad_cnt++;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, int'(fsm_state), 0);
        chk({tag, "_b1"}, int'(init_branch1), 0);
        chk({tag, "_b2"}, int'(init_branch2), 0);
        chk({tag, "_rb1"}, int'(rev_branch1), 0);
        chk({tag, "_rb2"}, int'(rev_branch2), 0);
        chk({tag, "_strobes"}, int'({valid_branch, rev_valid, done, in_ready}), 0);
    endtask

    task automatic run_block(input int len, input int start_step, input int abort_rev);
        int n, wt, f0, r0, d0, b0, e0, s0, code;
        n = q_sys.size();
        f0 = fwd_cnt; r0 = rev_cnt; d0 = done_cnt; b0 = bad_cnt; e0 = spacing_err; s0 = slog.size();
        fq.delete(); rq.delete();
        chk("idle_before", int'(fsm_state), 0);
        @(negedge clk); start = 1'b1; blk_len = (ADDR_W+1)'(len);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            sys_llr = 16'(q_sys[i]); apr_llr = 16'(q_apr[i]); par_llr = 16'(q_par[i]);
            in_valid = 1'b1;
            wt = 0;
            while (!in_ready && wt < 8) begin
                @(negedge clk); wt++;
            end
            if (!in_ready) begin
                fail_now("in_ready_wait");
                break;
            end
            if (i == 0) chk("first_ready_wait", wt, 0);
            else        chk("gap_ready_wait", wt, 1);
            fq.push_back('{q_e1[i], q_e2[i]});
            rq.push_front('{q_e1[i], q_e2[i]});
            if (i == start_step) begin
                start = 1'b1; blk_len = 3;
            end
            @(negedge clk); start = 1'b0;
        end
        if (abort_rev > 0) begin
            wt = 0;
            while (rev_cnt - r0 < abort_rev && wt < 200) begin
                @(negedge clk); wt++;
            end
            if (rev_cnt - r0 < abort_rev) fail_now("abort_rev_wait");
            chk("pre_abort_state", int'(fsm_state), 2);
            rst_n = 1'b0; in_valid = 1'b0;
            #1;
            check_all_zero("abort");
            fq.delete(); rq.delete();
            @(negedge clk); rst_n = 1'b1;
            return;
        end
        wt = 0;
        while (done_cnt == d0 && wt < 3000) begin
            @(negedge clk); wt++;
        end
        if (done_cnt == d0) fail_now("done_wait");
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("fwd_count", fwd_cnt - f0, n);
        chk("rev_count", rev_cnt - r0, n);
        chk("done_count", done_cnt - d0, 1);
        chk("fwd_left", fq.size(), 0);
        chk("rev_left", rq.size(), 0);
        chk("strobe_spacing", spacing_err - e0, 0);
        chk("ready_or_done_misplaced", bad_cnt - b0, 0);
        chk("bwd_after_last_fwd", t_bwd - last_fwd_cyc, 1);
        chk("first_rev_latency", t_first_rev - t_bwd, 2);
        chk("state_seq_len", slog.size() - s0, 4);
        code = 0;
        for (int j = s0; j < slog.size(); j++) code = code * 4 + slog[j];
        chk("state_seq", code, ((1 * 4 + 2) * 4 + 3) * 4 + 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; blk_len = '0;
        sys_llr = '0; par_llr = '0; apr_llr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        clear_vec();
        add(10, 4, 6, 10, 4);
        add(-7, 0, 0, -4, -4);
        add(0, 0, 5, 2, -3);
        add(1, 1, 1, 1, 0);
        run_block(4, -1, 0);

        clear_vec();
`ifdef BM_SAT_EN
        add(32767, 32767, 32767, 32767, 16383);
        add(-32768, -32768, 32767, -16385, -32768);
`else
        add(32767, 32767, 32767, -16386, 16383);
        add(-32768, -32768, 32767, -16385, 16384);
`endif
        run_block(2, -1, 0);

        clear_vec();
        for (int i = 0; i < 8; i++) add_model(i * 1000 - 4000, -i * 7, i * 13);
        run_block(8, 3, 0);

        @(negedge clk); start = 1'b1; blk_len = '0;
        @(negedge clk); start = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (fsm_state != 2'b00 || in_ready) bad++;
        end
        chk("len0_ignored", bad, 0);

        clear_vec();
        for (int i = 0; i < 512; i++)
            add_model(((i * 7919) % 65536) - 32768, ((i * 104729) % 65536) - 32768,
                      ((i * 31337 + 12345) % 65536) - 32768);
        run_block(600, -1, 0);

        clear_vec();
        for (int i = 0; i < 6; i++) add_model(i * 100 - 250, 3 * i, -i);
        run_block(6, -1, 3);

        clear_vec();
        add(5, -2, 1, 2, 1);
        add(-3, -3, 4, -1, -5);
        run_block(2, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
